vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_timing_gen_sig_delay.sv | 32 +++
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, coordinate width and sync polarity shared by
// the timing generator, renderers and compositor.
package vga_pkg;

    localparam int CW = 10;
    localparam int COORD_RANGE = 1 << CW;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam logic SYNC_ACT_LOW  = 1'b0;
    localparam logic SYNC_ACT_HIGH = 1'b1;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    // Bounds are one bit wider than a coordinate so an end bound of 1024 stays representable
    function automatic logic in_span(input logic [CW:0] x, input logic [CW:0] lo,
                                     input logic [CW:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sig_delay.sv
// sig_delay: W-bit, DEPTH-stage shift register advancing on ce with async clear to CLR.
// DEPTH=0 is a wire, forced to CLR while reset is held.
module sig_delay #(
    parameter int           W     = 3,
    parameter int           DEPTH = 1,
    parameter logic [W-1:0] CLR   = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused;
        assign w_unused = clk ^ ce;
        assign o_q = rst ? CLR : i_d;
    end else begin : g_sr
        logic [W-1:0] r_sr [DEPTH];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) r_sr[i] <= CLR;
            end else if (ce) begin
                r_sr[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
            end
        end
        assign o_q = r_sr[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA scan counters plus hsync/vsync/de strobes, delayed by PIPE_DLY
// pixel ticks to line up with renderer ROM outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = SYNC_ACT_LOW,
    parameter int   PIPE_DLY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] h_line,
    output logic [CW-1:0] v_line,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW:0]   HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0]   HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]   VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0]   VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW:0]   H_VIS  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]   V_VIS  = (CW+1)'(V_ACTIVE);

    localparam sync_t IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0};

    if (H_TOTAL > COORD_RANGE || V_TOTAL > COORD_RANGE) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be within 0..7");
    end

    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          r_fs;
    logic          w_h_wrap;
    logic          w_v_wrap;
    sync_t         w_raw;
    sync_t         w_dly;

    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);

    // frame_start is set by the edge that leaves the last pixel, so it reads 1 at (0,0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h  <= '0;
            r_v  <= '0;
            r_fs <= 1'b0;
        end else if (ce) begin
            r_h  <= w_h_wrap ? '0 : r_h + 1'b1;
            r_v  <= w_h_wrap ? (w_v_wrap ? '0 : r_v + 1'b1) : r_v;
            r_fs <= w_h_wrap && w_v_wrap;
        end
    end

    always_comb begin
        w_raw.hsync = in_span({1'b0, r_h}, HS_BEG, HS_END) ? SYNC_POL : ~SYNC_POL;
        w_raw.vsync = in_span({1'b0, r_v}, VS_BEG, VS_END) ? SYNC_POL : ~SYNC_POL;
        w_raw.de    = ({1'b0, r_h} < H_VIS) && ({1'b0, r_v} < V_VIS);
    end

    sig_delay #(
        .W    (3),
        .DEPTH(PIPE_DLY),
        .CLR  (IDLE)
    ) u_dly (
        .clk(clk),
        .rst(rst),
        .ce (ce),
        .i_d(w_raw),
        .o_q(w_dly)
    );

    assign h_line      = r_h;
    assign v_line      = r_v;
    assign hsync       = w_dly.hsync;
    assign vsync       = w_dly.vsync;
    assign de          = w_dly.de;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen at default 640x480 timing with
// PIPE_DLY 0/1/4, plus a 16x9 active-high instance for whole-frame and ce checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;

    always #5 clk = ~clk;

    logic [9:0] h_def, v_def, h_d0, v_d0, h_d4, v_d4, h_sm, v_sm;
    logic hs_def, vs_def, de_def, fs_def;
    logic hs_d0, vs_d0, de_d0, fs_d0;
    logic hs_d4, vs_d4, de_d4, fs_d4;
    logic hs_sm, vs_sm, de_sm, fs_sm;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .ce(ce), .h_line(h_def), .v_line(v_def),
        .hsync(hs_def), .vsync(vs_def), .de(de_def), .frame_start(fs_def)
    );

    vga_timing_gen #(.PIPE_DLY(0)) u_d0 (
        .clk(clk), .rst(rst), .ce(ce), .h_line(h_d0), .v_line(v_d0),
        .hsync(hs_d0), .vsync(vs_d0), .de(de_d0), .frame_start(fs_d0)
    );

    vga_timing_gen #(.PIPE_DLY(4)) u_d4 (
        .clk(clk), .rst(rst), .ce(ce), .h_line(h_d4), .v_line(v_d4),
        .hsync(hs_d4), .vsync(vs_d4), .de(de_d4), .frame_start(fs_d4)
    );

    // 16 x 9 timing: hsync 10..12, vsync lines 5..6, 8x4 visible, sync active-high
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .PIPE_DLY(1)
    ) u_sm (
        .clk(clk), .rst(rst), .ce(ce), .h_line(h_sm), .v_line(v_sm),
        .hsync(hs_sm), .vsync(vs_sm), .de(de_sm), .frame_start(fs_sm)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int first_def, first_d4, last_e;
    int fall_h, rise_h, fall_e, width, de_cnt, hs_low;
    int fs1, fs2, n_fs, fs_h, fs_v, vs_cnt, hs_cnt, l8_rise, l8_fall;
    logic prev_hs;

    initial begin
        rst = 1'b1;
        ce  = 1'b1;
        repeat (3) step();
        chk("por_h", h_def, 0);
        chk("por_fs", fs_def, 0);
        rst = 1'b0;
        repeat (300) step();
        chk("run_h300", h_def, 300);
        chk("run_de_on", de_def, 1);

        // asynchronous reset mid-line, checked before any clock edge
        rst = 1'b1;
        #1;
        chk("rst_h", h_def, 0);
        chk("rst_v", v_def, 0);
        chk("rst_de", de_def, 0);
        chk("rst_hsync", hs_def, 1);
        chk("rst_vsync", vs_def, 1);
        chk("rst_fs", fs_def, 0);
        chk("rst_sm_hsync", hs_sm, 0);
        chk("rst_sm_vsync", vs_sm, 0);
        chk("rst_d0_de", de_d0, 0);
        chk("rst_d4_de", de_d4, 0);
        step();
        rst = 1'b0;
        #1;
        chk("d0_de_coincident", de_d0, 1);
        chk("d1_de_before_edge", de_def, 0);

        // line 0 of the default timing
        first_def = -1; first_d4 = -1; fall_h = -1; rise_h = -1; fall_e = 0; width = -1;
        de_cnt = 0; hs_low = 0; last_e = -1;
        prev_hs = hs_def;
        for (int e = 1; e <= 1000; e++) begin
            step();
            if (e == 1) chk("first_inc_h", h_def, 1);
            if (first_def < 0 && de_def) first_def = e;
            if (first_d4 < 0 && de_d4) first_d4 = e;
            if (prev_hs && !hs_def) begin fall_h = h_def; fall_e = e; end
            if (!prev_hs && hs_def) begin rise_h = h_def; width = e - fall_e; end
            de_cnt += int'(de_def);
            hs_low += int'(!hs_def);
            prev_hs = hs_def;
            if (h_def == 0) begin last_e = e; break; end
        end
        chk("line_ticks", last_e, 800);
        chk("line_v_inc", v_def, 1);
        chk("d1_de_rise_tick", first_def, 1);
        chk("d4_de_rise_tick", first_d4, 4);
        chk("hsync_fall_h", fall_h, 657);
        chk("hsync_rise_h", rise_h, 753);
        chk("hsync_width", width, 96);
        chk("hsync_low_cnt", hs_low, 96);
        chk("de_line_cnt", de_cnt, 640);

        // whole frames on the small instance
        rst = 1'b1;
        step();
        rst = 1'b0;
        fs1 = -1; fs2 = -1; n_fs = 0; fs_h = -1; fs_v = -1;
        vs_cnt = 0; hs_cnt = 0; de_cnt = 0; l8_rise = -1; l8_fall = -1;
        prev_hs = hs_sm;
        for (int e = 1; e <= 400; e++) begin
            step();
            if (fs_sm) begin
                n_fs++;
                if (fs1 < 0) begin fs1 = e; fs_h = h_sm; fs_v = v_sm; end
                else if (fs2 < 0) fs2 = e;
            end
            if (fs1 > 0 && fs2 < 0 && e > fs1) begin
                vs_cnt += int'(vs_sm);
                hs_cnt += int'(hs_sm);
                de_cnt += int'(de_sm);
            end
            if (fs2 == e) begin
                vs_cnt += int'(vs_sm);
                hs_cnt += int'(hs_sm);
                de_cnt += int'(de_sm);
            end
            if (v_sm == 8 && !prev_hs && hs_sm && l8_rise < 0) l8_rise = h_sm;
            if (v_sm == 8 && prev_hs && !hs_sm && l8_fall < 0) l8_fall = h_sm;
            prev_hs = hs_sm;
        end
        chk("sm_fs_first", fs1, 144);
        chk("sm_fs_period", fs2 - fs1, 144);
        chk("sm_fs_count", n_fs, 2);
        chk("sm_fs_h", fs_h, 0);
        chk("sm_fs_v", fs_v, 0);
        chk("sm_vsync_cnt", vs_cnt, 32);
        chk("sm_hsync_cnt", hs_cnt, 27);
        chk("sm_de_cnt", de_cnt, 32);
        chk("sm_last_line_hs_rise", l8_rise, 11);
        chk("sm_last_line_hs_fall", l8_fall, 14);

        // ce every other clock
        rst = 1'b1;
        step();
        rst = 1'b0;
        fs1 = -1; n_fs = 0; vs_cnt = 0; de_cnt = 0;
        for (int e = 1; e <= 320; e++) begin
            ce = (e % 2) == 1;
            step();
            if (e == 1) chk("ce_h_e1", h_sm, 1);
            if (e == 2) chk("ce_h_e2_hold", h_sm, 1);
            if (e == 3) chk("ce_h_e3", h_sm, 2);
            if (fs_sm) begin
                n_fs++;
                if (fs1 < 0) fs1 = e;
            end
            if (e <= 288) begin
                vs_cnt += int'(vs_sm);
                de_cnt += int'(de_sm);
            end
        end
        ce = 1'b1;
        chk("ce_fs_first", fs1, 287);
        chk("ce_fs_stretch", n_fs, 2);
        chk("ce_vsync_cnt", vs_cnt, 64);
        chk("ce_de_cnt", de_cnt, 64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
